mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Iterative multiply/divide unit fed by the register file read ports (readData1 -> src_a, readData2 -> src_b).
//   Executes MULT/MULTU/DIV/DIVU over WIDTH iterations and holds the result in HI/LO, which the write-back mux reads.
//   The stall logic uses busy to freeze issue; done tells the controller the result is valid.
// PARAMETERS
//   WIDTH   32   operand width; HI/LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//   clk           in   1      system clock, rising-edge active
//   rst_n         in   1      asynchronous active-low reset
//   start         in   1      request; sampled only in IDLE
//   op            in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   src_a         in   WIDTH  multiplicand / dividend
//   src_b         in   WIDTH  multiplier / divisor
//   busy          out  1      high from the edge that accepts start until the edge that raises done
//   done          out  1      one-cycle pulse; hi/lo/div_by_zero valid from this cycle on
//   hi            out  WIDTH  MUL: product[2W-1:W]; DIV: remainder
//   lo            out  WIDTH  MUL: product[W-1:0];  DIV: quotient
//   div_by_zero   out  1      set with done when a DIV/DIVU had src_b==0; cleared with done otherwise
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0, internal regs=0.
//   FSM states:
//     IDLE --start--> RUN. Latch op, |src_a|, |src_b| (magnitudes for signed ops), result signs; cnt=0.
//     RUN: one shift-add (MUL) or restoring shift-subtract (DIV) step per edge, cnt++. When cnt reaches WIDTH-1 -> FINISH.
//     FINISH: apply sign correction, write hi/lo/div_by_zero, pulse done, go to IDLE.
//   Timing: start accepted at edge E0; iterations at E1..EW; hi/lo/done registered at E(W+1).
//     Fixed latency: W+1 edges, regardless of operand values or op.
//     busy=1 after E0 until E(W+1).
//     A start in the done cycle is accepted (back-to-back issue = W+2 cycle period).
//   start while busy: ignored. No queueing, no effect on the operation in flight.
//   Inputs: src_a/src_b/op may change after E0; only the latched copies are used.
//   Signs:
//     MULT: product negated if sign(a)^sign(b).
//     DIV: quotient negated if sign(a)^sign(b); remainder takes the sign of the dividend.
//   Arithmetic: all arithmetic is modulo 2^W per half. Overflow: DIV 0x8000_0000 / -1 -> lo=0x8000_0000, hi=0.
//   Divide by zero (src_b==0, DIV or DIVU): fixed latency kept.
//     Result: hi=src_a as latched (unsigned raw value), lo=all ones, div_by_zero=1.
//   Hold: hi/lo/div_by_zero hold their value between completions; hi/lo change only at a done edge.
//   Reset mid-operation: abort immediately; all outputs return to reset values; no done pulse is produced.
// TESTING
//   1 MULTU 0xFFFFFFFF*0xFFFFFFFF -> done exactly 33 edges after the start edge; hi=FFFFFFFE lo=00000001 dbz=0.
//   2 MULT -3*7 -> hi=FFFFFFFF lo=FFFFFFEB; then DIV -7/2 issued in the done cycle -> lo=FFFFFFFD hi=FFFFFFFF.
//   3 DIVU 10/0 -> hi=0000000A lo=FFFFFFFF dbz=1 at 33 edges; a following MULTU 2*3 -> lo=6 hi=0 dbz=0.
//   4 DIV 0x80000000 / 0xFFFFFFFF -> lo=80000000 hi=00000000 dbz=0.
//   5 start pulsed and src_a/src_b changed at edge 5 of a DIVU 100/7 -> extra start ignored; result lo=14 hi=2, single done pulse.
//   6 rst_n low at edge 10 of a MULTU -> busy=0 done=0 hi=lo=0 at once; no done afterwards; a new op completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: MULT/MULTU via shift-add, DIV/DIVU via
// restoring shift-subtract, fixed WIDTH+1 edge latency, result held in HI/LO.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;         // product / quotient negation
  logic               rem_neg_q, rem_neg_d; // remainder takes dividend sign
  logic               b_zero_q, b_zero_d;
  logic [WIDTH-1:0]   addend_q, addend_d;   // |a| for MUL, |b| for DIV
  logic [WIDTH-1:0]   acc_q, acc_d;         // product high / partial remainder
  logic [WIDTH-1:0]   low_q, low_d;         // multiplier-product low / dividend-quotient
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [PW-1:0]      prod_raw;
  logic [PW-1:0]      prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes, single iteration step and final sign correction
  always_comb begin
    a_neg     = op[0] & src_a[WIDTH-1];
    b_neg     = op[0] & src_b[WIDTH-1];
    mag_a     = a_neg ? (~src_a + WIDTH'(1)) : src_a;
    mag_b     = b_neg ? (~src_b + WIDTH'(1)) : src_b;
    mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, addend_q} : (WIDTH+1)'(0));
    div_shift = {acc_q, low_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, addend_q};
    div_ge    = ~div_diff[WIDTH];
    prod_raw  = {acc_q, low_q};
    prod_fix  = neg_q ? (~prod_raw + PW'(1)) : prod_raw;
    quo_fix   = neg_q ? (~low_q + WIDTH'(1)) : low_q;
    rem_fix   = rem_neg_q ? (~acc_q + WIDTH'(1)) : acc_q;
  end

  // Next-state and next-register computation for the sequencer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    b_zero_d  = b_zero_q;
    addend_d  = addend_q;
    acc_d     = acc_q;
    low_d     = low_q;
    raw_a_d   = raw_a_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          busy_d    = 1'b1;
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          b_zero_d  = (src_b == '0);
          addend_d  = op[1] ? mag_b : mag_a;
          low_d     = op[1] ? mag_a : mag_b;
          acc_d     = '0;
          raw_a_d   = src_a;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          low_d = {low_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          low_d = {mul_sum[0], low_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div_q) begin
          if (b_zero_q) begin
            hi_d  = raw_a_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d  = rem_fix;
            lo_d  = quo_fix;
            dbz_d = 1'b0;
          end
        end else begin
          hi_d  = prod_fix[PW-1:WIDTH];
          lo_d  = prod_fix[WIDTH-1:0];
          dbz_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous abort on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
      addend_q  <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      raw_a_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      b_zero_q  <= b_zero_d;
      addend_q  <= addend_d;
      acc_q     <= acc_d;
      low_q     <= low_d;
      raw_a_q   <= raw_a_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected results queued at issue,
// compared (value and latency) when done pulses.
module tb_mult_div_unit;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          div_by_zero;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           cyc;
  int           n_assert;
  int           n_fail;
  logic [W-1:0] last_hi;
  logic [W-1:0] last_lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert = n_assert + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Independent reference using 64-bit arithmetic
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sbv, q, r;
    logic [63:0] p;
    e.cyc = 0;
    e.dbz = 1'b0;
    if (o[1]) begin
      if (b == '0) begin
        e.hi  = a;
        e.lo  = '1;
        e.dbz = 1'b1;
      end else if (o[0]) begin
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        q    = sa / sbv;
        r    = sa % sbv;
        e.lo = q[W-1:0];
        e.hi = r[W-1:0];
      end else begin
        e.lo = a / b;
        e.hi = a % b;
      end
    end else begin
      if (o[0]) begin
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        p   = 64'(sa * sbv);
      end else begin
        p = {32'd0, a} * {32'd0, b};
      end
      e.hi = p[63:32];
      e.lo = p[31:0];
    end
    return e;
  endfunction

  // Drive start for one cycle from a negedge; queue the expected result
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz);
    exp_t e;
    e.hi  = ehi;
    e.lo  = elo;
    e.dbz = edbz;
    e.cyc = cyc + 1 + int'(LAT);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(o, a, b);
    issue(o, a, b, e.hi, e.lo, e.dbz);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check_eq(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check_eq(tag, 64'(done), 64'd1);
  endtask

  // Monitor: every done must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      check_eq("done_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("hi", 64'(hi), 64'(e.hi));
        check_eq("lo", 64'(lo), 64'(e.lo));
        check_eq("dbz", 64'(div_by_zero), 64'(e.dbz));
        check_eq("latency_cyc", 64'(cyc), 64'(e.cyc));
        check_eq("busy_at_done", 64'(busy), 64'd0);
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    last_hi  = '0;
    last_lo  = '0;
    start    = 1'b0;
    op       = 2'b00;
    src_a    = '0;
    src_b    = '0;
    rst_n    = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hilo", {hi, lo}, 64'd0);
    check_eq("rst_dbz", 64'(div_by_zero), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: MULTU max*max
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    check_eq("busy_after_start", 64'(busy), 64'd1);
    drain("drain_t1");

    // 2: MULT -3*7, then DIV -7/2 issued in the done cycle
    issue(2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    wait_done("t2_done_seen");
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    drain("drain_t2");

    // 3: DIVU 10/0 then MULTU 2*3 clears the flag
    issue(2'b10, 32'd10, 32'd0, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1);
    drain("drain_t3a");
    issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    drain("drain_t3b");

    // 4: signed overflow case
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    drain("drain_t4");

    // 5: start and operand changes mid-operation are ignored
    issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("busy_mid", 64'(busy), 64'd1);
    op    = 2'b00;
    src_a = 32'd55;
    src_b = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("drain_t5");
    repeat (40) @(negedge clk);
    check_eq("hold_hi", 64'(hi), 64'(last_hi));
    check_eq("hold_lo", 64'(lo), 64'(last_lo));

    // 6: reset mid-operation aborts with no done
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    check_eq("abort_no_result", {hi, lo}, 64'd0);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0);
    drain("drain_t6");

    // Random operations checked against the reference model
    for (int i = 0; i < 12; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom();
      rb = (i % 5 == 4) ? '0 : ((i % 3 == 0) ? W'($urandom_range(1, 300)) : $urandom());
      issue_model(ro, ra, rb);
      if (i % 2 == 0) begin
        wait_done("rand_b2b_done");
        issue_model(2'($urandom_range(0, 3)), $urandom(), W'($urandom_range(1, 1000)));
      end
      drain("drain_rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
